pin_entry_collector: RTL and testbench

//  Keypad front end for the PIN lock datapath. Gathers DIGITS hex key presses

---
 rtl/pin_entry_collector.sv | 124 ++++++++++++
 tb/tb_pin_entry_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_collector.sv
// rtl/pin_entry_collector.sv - keypad digit collector producing a packed PIN with enter/short/timeout strobes
module pin_entry_collector #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                key_enter,
    input  logic                key_clear,
    output logic [4*DIGITS-1:0] pin_out,
    output logic                pin_enter,
    output logic [2:0]          digit_cnt,
    output logic                full,
    output logic                short_err,
    output logic                timeout
);

    localparam int            PW       = 4 * DIGITS;
    localparam logic [2:0]    FULL_CNT = 3'(DIGITS);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);

    logic          key_valid_q, key_valid_d;
    logic          key_enter_q, key_enter_d;
    logic          key_clear_q, key_clear_d;
    logic [PW-1:0] buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] pin_out_q, pin_out_d;
    logic          enter_pend_q, enter_pend_d;
    logic          pin_enter_q, pin_enter_d;
    logic          short_err_q, short_err_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] idle_q, idle_d;

    logic valid_ev, enter_ev, clear_ev;

    always_comb begin
        valid_ev     = key_valid & ~key_valid_q;
        enter_ev     = key_enter & ~key_enter_q;
        clear_ev     = key_clear & ~key_clear_q;

        key_valid_d  = key_valid;
        key_enter_d  = key_enter;
        key_clear_d  = key_clear;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        pin_out_d    = pin_out_q;
        enter_pend_d = 1'b0;
        // pin_enter trails the pin_out load by one cycle so the word is already stable
        pin_enter_d  = enter_pend_q;
        short_err_d  = 1'b0;
        timeout_d    = 1'b0;
        idle_d       = idle_q;

        if (clear_ev) begin
            buf_d  = '0;
            cnt_d  = '0;
            idle_d = '0;
        end else if (enter_ev) begin
            if (cnt_q == FULL_CNT) begin
                pin_out_d    = buf_q;
                enter_pend_d = 1'b1;
            end else begin
                short_err_d  = 1'b1;
            end
            buf_d  = '0;
            cnt_d  = '0;
            idle_d = '0;
        end else if (valid_ev) begin
            if (cnt_q < FULL_CNT) begin
                buf_d = {buf_q[PW-5:0], key_code};
                cnt_d = cnt_q + 3'd1;
            end
            idle_d = '0;
        end else if (cnt_q == 3'd0) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            buf_d     = '0;
            cnt_d     = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
        end else begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            key_valid_q  <= 1'b0;
            key_enter_q  <= 1'b0;
            key_clear_q  <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            pin_out_q    <= '0;
            enter_pend_q <= 1'b0;
            pin_enter_q  <= 1'b0;
            short_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else begin
            key_valid_q  <= key_valid_d;
            key_enter_q  <= key_enter_d;
            key_clear_q  <= key_clear_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            pin_out_q    <= pin_out_d;
            enter_pend_q <= enter_pend_d;
            pin_enter_q  <= pin_enter_d;
            short_err_q  <= short_err_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
        end
    end

    assign pin_out   = pin_out_q;
    assign pin_enter = pin_enter_q;
    assign digit_cnt = cnt_q;
    assign full      = (cnt_q == FULL_CNT);
    assign short_err = short_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// tb/tb_pin_entry_collector.sv - scoreboard bench for pin_entry_collector
module tb_pin_entry_collector;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key_valid, key_enter, key_clear;
    logic [3:0]  key_code;
    logic [15:0] pin_out;
    logic        pin_enter, full, short_err, timeout;
    logic [2:0]  digit_cnt;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    typedef struct {
        int          kind;
        logic [15:0] pin;
    } exp_t;
    exp_t exp_q[$];

    pin_entry_collector #(.DIGITS(4), .TIMEOUT(TO), .TW(10)) dut (
        .clk(clk), .rstn(rstn),
        .key_valid(key_valid), .key_code(key_code),
        .key_enter(key_enter), .key_clear(key_clear),
        .pin_out(pin_out), .pin_enter(pin_enter),
        .digit_cnt(digit_cnt), .full(full),
        .short_err(short_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // kind 1 = pin_enter, 2 = short_err, 3 = timeout
    task automatic do_enter(input bit ok, input logic [15:0] exp_pin);
        exp_t e;
        e.kind = ok ? 1 : 2;
        e.pin  = exp_pin;
        exp_q.push_back(e);
        @(negedge clk);
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        chk("enter_pin_out", 32'(pin_out), 32'(exp_pin));
        chk("enter_cnt", 32'(digit_cnt), 32'd0);
        chk("enter_strobe_early", 32'(pin_enter), 32'd0);
        chk("enter_short_now", 32'(short_err), ok ? 32'd0 : 32'd1);
        @(negedge clk);
        chk("enter_strobe_late", 32'(pin_enter), ok ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    // monitor: pops one expectation per strobe cycle
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (!done && (pin_enter || short_err || timeout)) begin
                kind = pin_enter ? 1 : (short_err ? 2 : 3);
                checks++;
                if (int'(pin_enter) + int'(short_err) + int'(timeout) != 1) begin
                    errors++;
                    $display("FAIL strobe_excl: pe=%0b se=%0b to=%0b required one-hot", pin_enter, short_err, timeout);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: kind %0d with none expected", kind);
                end else begin
                    e = exp_q.pop_front();
                    if (kind != e.kind || pin_out !== e.pin) begin
                        errors++;
                        $display("FAIL strobe: kind %0d pin %0h expected kind %0d pin %0h", kind, pin_out, e.kind, e.pin);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   waited;
        rstn = 1'b1; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_code = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_pin_out", 32'(pin_out), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_strobes", 32'({pin_enter, short_err, timeout, full}), 32'd0);
        rstn = 1'b0;
        @(negedge clk);

        // 1: basic entry
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("t1_full", 32'(full), 32'd1);
        do_enter(1'b1, 16'h1234);
        chk("t1_full_after", 32'(full), 32'd0);

        // 2: held key gives one digit
        @(negedge clk);
        key_code = 4'h7; key_valid = 1'b1;
        repeat (20) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("t2_held_cnt", 32'(digit_cnt), 32'd1);
        press(4'h8); press(4'h9); press(4'hA);
        do_enter(1'b1, 16'h789A);

        // 3: short entry
        press(4'h5); press(4'h6);
        chk("t3_cnt", 32'(digit_cnt), 32'd2);
        do_enter(1'b0, 16'h789A);

        // 4: fifth digit ignored
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("t4_cnt", 32'(digit_cnt), 32'd4);
        chk("t4_full", 32'(full), 32'd1);
        do_enter(1'b1, 16'h1234);

        // 5: inactivity timeout after TO cycles
        e.kind = 3; e.pin = 16'h1234;
        exp_q.push_back(e);
        @(negedge clk);
        key_code = 4'h9; key_valid = 1'b1;
        waited = -1;
        for (int k = 0; k < TO + 10; k++) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (timeout) begin
                waited = k;
                break;
            end
        end
        chk("t5_timeout_delay", 32'(waited), 32'(TO));
        chk("t5_cnt", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        key_clear = 1'b1; key_enter = 1'b1;
        @(negedge clk);
        key_clear = 1'b0; key_enter = 1'b0;
        press(4'h3);
        @(negedge clk);
        key_clear = 1'b1; key_enter = 1'b1; key_valid = 1'b1; key_code = 4'h4;
        @(negedge clk);
        key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
        chk("t5_clear_cnt", 32'(digit_cnt), 32'd0);
        repeat (4) @(negedge clk);

        // 6: async reset mid-entry
        press(4'h1); press(4'h2); press(4'h3);
        chk("t6_cnt_before", 32'(digit_cnt), 32'd3);
        rstn = 1'b1;
        #1;
        chk("t6_rst_pin_out", 32'(pin_out), 32'd0);
        chk("t6_rst_cnt", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_post_pin_out", 32'(pin_out), 32'd0);
        chk("t6_post_strobes", 32'({pin_enter, short_err, timeout, full}), 32'd0);

        repeat (TO + 4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
